// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared definitions for the Game-of-Life evolution datapath.
//                It holds the generation-scheduler state encoding, the default
//                grid dimensions and the derived row/column index widths used
//                by the scheduler, cell engine and display scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package life_pkg;

    // Default grid dimensions, common to all grid-walking blocks
    localparam int c_GRID_ROWS = 32;
    localparam int c_GRID_COLS = 32;

    // Index widths for the default grid
    localparam int c_ROW_W = $clog2(c_GRID_ROWS);
    localparam int c_COL_W = $clog2(c_GRID_COLS);

    // Generation scheduler states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_SWAP  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/cell_scan_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : cell_scan_cnt
//  Description : Row-major grid coordinate counter. The column advances on
//                every enabled cycle and wraps into the next row. The walk
//                wraps from the last cell back to (0,0).
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_clr       - synchronous clear to (0,0), wins over i_en
//                i_en        - advance one cell
//                o_row/o_col - current coordinate (registered)
//                o_last      - current coordinate is (ROWS-1, COLS-1)
//  Revision    : 1.0  initial release
// ============================================================================
module cell_scan_cnt #(
    parameter int ROWS  = 32,
    parameter int COLS  = 32,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_wrap;
    logic             w_row_wrap;

    assign w_col_wrap = (r_col == c_COL_LAST);
    assign w_row_wrap = (r_row == c_ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (w_col_wrap) begin
                r_col <= '0;
                // Explicit wrap keeps non-power-of-two grids in range
                if (w_row_wrap) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_wrap && w_row_wrap;

endmodule
`default_nettype wire

// File: rtl/life_gen_sched.sv
`default_nettype none
// ============================================================================
//  Module      : life_gen_sched
//  Description : Generation scheduler. Turns speed-controller ticks (auto
//                mode) or step presses (manual mode) into full-grid passes:
//                one valid/ready request per cell in row-major order, a wait
//                for the cell engine to drain, then a ping-pong buffer swap.
//                One trigger can be held pending while busy or paused. Any
//                further trigger is dropped and flagged on overrun.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                mode              - 1 = auto (tick), 0 = manual (step)
//                tick, step        - one-cycle trigger pulses
//                pause             - level, holds off new passes only
//                req_valid/row/col - cell-update request to the engine
//                req_ready         - engine accepts request
//                eng_idle          - engine pipeline empty
//                buf_sel           - read buffer index (engine writes ~buf_sel)
//                busy              - pass in progress
//                gen_done          - one-cycle pulse at buffer swap
//                gen_count         - completed generations (wrapping)
//                overrun           - one-cycle pulse when a trigger is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module life_gen_sched
    import life_pkg::*;
#(
    parameter int ROWS  = c_GRID_ROWS,
    parameter int COLS  = c_GRID_COLS,
    parameter int GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    tick,
    input  logic                    step,
    input  logic                    pause,
    output logic                    req_valid,
    output logic [$clog2(ROWS)-1:0] req_row,
    output logic [$clog2(COLS)-1:0] req_col,
    input  logic                    req_ready,
    input  logic                    eng_idle,
    output logic                    buf_sel,
    output logic                    busy,
    output logic                    gen_done,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    overrun
);

    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_COL_W = $clog2(COLS);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;

    logic             r_pending;
    logic             w_pending_nxt;
    logic             r_req_valid;
    logic             r_busy;
    logic             r_gen_done;
    logic             r_buf_sel;
    logic [GEN_W-1:0] r_gen_count;
    logic             r_overrun;

    logic             w_trig;
    logic             w_start;
    logic             w_accept;
    logic             w_swap;
    logic             w_last;
    logic             w_scan_clr;

    logic [c_ROW_W-1:0] w_row;
    logic [c_COL_W-1:0] w_col;

    // Only the source selected by the current mode can trigger
    assign w_trig   = mode ? tick : step;

    // A pass starts from IDLE on a fresh trigger or a pending one
    assign w_start  = (r_state == S_IDLE) && !pause && (w_trig || r_pending);

    // req_valid is high for exactly the SCAN state
    assign w_accept = r_req_valid && req_ready;

    // Swap is decided on the DRAIN->SWAP edge so buf_sel, gen_count and
    // gen_done all become visible during the single SWAP cycle
    assign w_swap   = (r_state == S_DRAIN) && eng_idle;

    // Counter sits at (0,0) whenever not scanning, so every pass and any
    // post-reset pass begins at the origin
    assign w_scan_clr = (r_state != S_SCAN);

    cell_scan_cnt #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (c_ROW_W),
        .COL_W (c_COL_W)
    ) u_scan_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_scan_clr),
        .i_en   (w_accept),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (eng_idle) begin
                    w_state_nxt = S_SWAP;
                end
            end
            S_SWAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pending is one deep. A trigger that does not start a pass (busy or
    // paused) sets it; starting a pass consumes it. A trigger arriving while
    // it is already set is dropped and reported.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_start) begin
            w_pending_nxt = 1'b0;
        end else if (w_trig) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_gen_done  <= 1'b0;
            r_buf_sel   <= 1'b0;
            r_gen_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_req_valid <= (w_state_nxt == S_SCAN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_gen_done  <= w_swap;
            r_overrun   <= w_trig && r_pending;
            if (w_swap) begin
                r_buf_sel   <= ~r_buf_sel;
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
        end
    end

    assign req_valid = r_req_valid;
    assign req_row   = w_row;
    assign req_col   = w_col;
    assign buf_sel   = r_buf_sel;
    assign busy      = r_busy;
    assign gen_done  = r_gen_done;
    assign gen_count = r_gen_count;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_life_gen_sched
//  Description : Self-checking bench for life_gen_sched on a 4x4 grid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_gen_sched;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int GEN_W = 16;
    localparam int CELLS = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mode = 1'b1;
    logic             tick = 1'b0;
    logic             step = 1'b0;
    logic             pause = 1'b0;
    logic             req_ready = 1'b1;
    logic             eng_idle = 1'b1;
    logic             req_valid;
    logic [1:0]       req_row;
    logic [1:0]       req_col;
    logic             buf_sel;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    logic             overrun;

    life_gen_sched #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .GEN_W (GEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .tick      (tick),
        .step      (step),
        .pause     (pause),
        .req_valid (req_valid),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_ready (req_ready),
        .eng_idle  (eng_idle),
        .buf_sel   (buf_sel),
        .busy      (busy),
        .gen_done  (gen_done),
        .gen_count (gen_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: generations completed and resulting read buffer
    logic [GEN_W-1:0] exp_gen = '0;
    logic             exp_buf = 1'b0;

    // req_ready pattern: 0 = always 1, 1 = toggle, 2 = random
    int rdy_mode = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       req_ready = ~req_ready;
            2:       req_ready = 1'($urandom_range(0, 1));
            default: req_ready = 1'b1;
        endcase
    end

    // Observation log, sampled mid-cycle
    int cyc = 0;
    int hs_row[$];
    int hs_col[$];
    int hs_cyc[$];
    int done_cnt = 0;
    int ovr_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (req_valid && req_ready) begin
            hs_row.push_back(int'(req_row));
            hs_col.push_back(int'(req_col));
            hs_cyc.push_back(cyc);
        end
        if (gen_done) done_cnt++;
        if (overrun) ovr_cnt++;
    end

    // Handshake k of a run of passes must address cell (k mod CELLS) in
    // row-major order; returns the number of deviations.
    function automatic int seq_errors(input int h0, input int npass);
        int bad = 0;
        if (hs_row.size() != h0 + npass * CELLS) bad++;
        for (int k = 0; k < npass * CELLS && h0 + k < hs_row.size(); k++) begin
            if (hs_row[h0+k] != (k % CELLS) / COLS || hs_col[h0+k] != k % COLS) bad++;
        end
        return bad;
    endfunction

    task automatic clk_step;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_tick;
        tick = 1'b1;
        clk_step;
        tick = 1'b0;
    endtask

    task automatic pulse_step;
        step = 1'b1;
        clk_step;
        step = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt >= target && !busy) begin
                ok = 1'b1;
                break;
            end
            clk_step;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clk_step;
        clk_step;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        checks++; if (req_row !== 2'd0 || req_col !== 2'd0) begin errors++; $display("FAIL reset_coord: got (%0d,%0d) want (0,0)", req_row, req_col); end
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL reset_buf_sel: got %b want 0", buf_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (gen_done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b ovr=%b want 0/0", gen_done, overrun); end
        checks++; if (gen_count !== '0) begin errors++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
        rst = 1'b0;
        exp_gen = '0;
        exp_buf = 1'b0;
        clk_step;
    endtask

    task automatic test_basic;
        int h0 = hs_row.size();
        int d0 = done_cnt;
        int n = 0;
        bit ok;
        rdy_mode = 0; eng_idle = 1'b1; mode = 1'b1;
        pulse_tick;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %b want 1", req_valid); end
        for (int i = 0; i < 40 && req_valid === 1'b1; i++) begin
            n++;
            clk_step;
        end
        checks++; if (n != CELLS) begin errors++; $display("FAIL basic_valid_cycles: got %0d want %0d", n, CELLS); end
        wait_done(d0 + 1, 40, ok);
        exp_gen = exp_gen + 1'b1; exp_buf = ~exp_buf;
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy=%b want 0", busy); end
        checks++; if (seq_errors(h0, 1) != 0) begin errors++; $display("FAIL basic_coords: got %0d bad entries want 0", seq_errors(h0, 1)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_gen_done: got %0d pulses want 1", done_cnt - d0); end
        checks++; if (gen_count !== exp_gen || buf_sel !== exp_buf) begin errors++; $display("FAIL basic_swap: got gen=%0d buf=%b want gen=%0d buf=%b", gen_count, buf_sel, exp_gen, exp_buf); end
    endtask

    task automatic test_backpressure;
        int h0 = hs_row.size();
        bit held = 1'b0;
        logic [1:0] hr = '0;
        logic [1:0] hc = '0;
        rdy_mode = 1; eng_idle = 1'b1; mode = 1'b1;
        pulse_tick;
        for (int i = 0; i < 120 && busy === 1'b1; i++) begin
            if (held) begin
                checks++;
                if (req_valid !== 1'b1 || req_row !== hr || req_col !== hc) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", req_valid, req_row, req_col, hr, hc);
                end
            end
            held = req_valid && !req_ready;
            hr = req_row; hc = req_col;
            clk_step;
        end
        rdy_mode = 0;
        exp_gen = exp_gen + 1'b1; exp_buf = ~exp_buf;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_timeout: got busy=%b want 0", busy); end
        checks++; if (seq_errors(h0, 1) != 0) begin errors++; $display("FAIL bp_coords: got %0d bad entries want 0", seq_errors(h0, 1)); end
        if (hs_cyc.size() >= h0 + CELLS) begin
            checks++;
            if (hs_cyc[h0+CELLS-1] - hs_cyc[h0] != 2 * (CELLS - 1)) begin
                errors++;
                $display("FAIL bp_span: got %0d cycles want %0d", hs_cyc[h0+CELLS-1] - hs_cyc[h0], 2 * (CELLS - 1));
            end
        end
        checks++; if (gen_count !== exp_gen) begin errors++; $display("FAIL bp_gen_count: got %0d want %0d", gen_count, exp_gen); end
    endtask

    task automatic test_drain;
        int hold_bad = 0;
        rdy_mode = 0; eng_idle = 1'b1; mode = 1'b1;
        pulse_tick;
        for (int i = 0; i < 40 && req_valid === 1'b1; i++) clk_step;
        eng_idle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_step;
            if (busy !== 1'b1 || gen_done !== 1'b0 || gen_count !== exp_gen) hold_bad++;
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL drain_hold: got %0d bad cycles want 0", hold_bad); end
        eng_idle = 1'b1;
        clk_step;
        exp_gen = exp_gen + 1'b1; exp_buf = ~exp_buf;
        checks++; if (gen_done !== 1'b1) begin errors++; $display("FAIL drain_done_timing: got %b want 1", gen_done); end
        checks++; if (gen_count !== exp_gen || buf_sel !== exp_buf) begin errors++; $display("FAIL drain_swap: got gen=%0d buf=%b want gen=%0d buf=%b", gen_count, buf_sel, exp_gen, exp_buf); end
        clk_step;
        checks++; if (gen_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drain_after: got done=%b busy=%b want 0/0", gen_done, busy); end
    endtask

    task automatic test_overrun;
        int h0 = hs_row.size();
        int d0 = done_cnt;
        int o0 = ovr_cnt;
        bit ok;
        rdy_mode = 0; eng_idle = 1'b1; mode = 1'b1;
        pulse_tick;
        repeat (3) clk_step;
        pulse_tick;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_extra: got %b want 0", overrun); end
        repeat (2) clk_step;
        pulse_tick;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        repeat (2) clk_step;
        pulse_tick;
        wait_done(d0 + 2, 200, ok);
        repeat (20) clk_step;
        exp_gen = exp_gen + 2'd2;
        checks++; if (!ok || done_cnt - d0 != 2) begin errors++; $display("FAIL ovr_passes: got %0d want 2", done_cnt - d0); end
        checks++; if (ovr_cnt - o0 != 2) begin errors++; $display("FAIL ovr_count: got %0d want 2", ovr_cnt - o0); end
        checks++; if (seq_errors(h0, 2) != 0) begin errors++; $display("FAIL ovr_coords: got %0d bad entries want 0", seq_errors(h0, 2)); end
        checks++; if (gen_count !== exp_gen || buf_sel !== exp_buf) begin errors++; $display("FAIL ovr_gen: got gen=%0d buf=%b want gen=%0d buf=%b", gen_count, buf_sel, exp_gen, exp_buf); end
    endtask

    task automatic test_manual;
        int h0 = hs_row.size();
        int d0 = done_cnt;
        bit ok;
        rdy_mode = 0; eng_idle = 1'b1; mode = 1'b0;
        pulse_tick;
        repeat (10) clk_step;
        checks++; if (busy !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL man_tick_ignored: got busy=%b passes=%0d want 0/0", busy, done_cnt - d0); end
        pulse_step;
        wait_done(d0 + 1, 60, ok);
        exp_gen = exp_gen + 1'b1; exp_buf = ~exp_buf;
        checks++; if (!ok || gen_count !== exp_gen) begin errors++; $display("FAIL man_step_pass: got gen=%0d want %0d", gen_count, exp_gen); end
        pause = 1'b1;
        pulse_step;
        repeat (10) clk_step;
        checks++; if (busy !== 1'b0 || done_cnt != d0 + 1) begin errors++; $display("FAIL man_paused: got busy=%b passes=%0d want 0/1", busy, done_cnt - d0); end
        pause = 1'b0;
        clk_step;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL man_unpause_start: got %b want 1", req_valid); end
        wait_done(d0 + 2, 60, ok);
        exp_gen = exp_gen + 1'b1; exp_buf = ~exp_buf;
        checks++; if (!ok || gen_count !== exp_gen || buf_sel !== exp_buf) begin errors++; $display("FAIL man_unpause_pass: got gen=%0d buf=%b want gen=%0d buf=%b", gen_count, buf_sel, exp_gen, exp_buf); end
        checks++; if (seq_errors(h0, 2) != 0) begin errors++; $display("FAIL man_coords: got %0d bad entries want 0", seq_errors(h0, 2)); end
        mode = 1'b1;
    endtask

    task automatic test_mid_reset;
        int h1;
        int d1;
        int n = 0;
        bit ok;
        rdy_mode = 0; eng_idle = 1'b1; mode = 1'b1;
        pulse_tick;
        repeat (6) clk_step;
        rst = 1'b1;
        clk_step;
        checks++; if (req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_idle: got v=%b busy=%b want 0/0", req_valid, busy); end
        checks++; if (buf_sel !== 1'b0 || gen_count !== '0) begin errors++; $display("FAIL mrst_state: got buf=%b gen=%0d want 0/0", buf_sel, gen_count); end
        rst = 1'b0;
        exp_gen = '0; exp_buf = 1'b0;
        clk_step;
        h1 = hs_row.size();
        d1 = done_cnt;
        pulse_tick;
        for (int i = 0; i < 40 && req_valid === 1'b1; i++) begin
            n++;
            clk_step;
        end
        wait_done(d1 + 1, 40, ok);
        exp_gen = exp_gen + 1'b1; exp_buf = ~exp_buf;
        checks++; if (n != CELLS || seq_errors(h1, 1) != 0) begin errors++; $display("FAIL mrst_clean_pass: got %0d valid cycles, %0d bad coords want %0d/0", n, seq_errors(h1, 1), CELLS); end
        checks++; if (!ok || gen_count !== exp_gen || buf_sel !== exp_buf) begin errors++; $display("FAIL mrst_gen: got gen=%0d buf=%b want gen=%0d buf=%b", gen_count, buf_sel, exp_gen, exp_buf); end
    endtask

    // Random ready, random drain latency, random ignored step presses and
    // random extra ticks during the scan of the first pass.
    task automatic test_random;
        for (int p = 0; p < 6; p++) begin
            int h0 = hs_row.size();
            int d0 = done_cnt;
            int o0 = ovr_cnt;
            int want_extra = int'($urandom_range(0, 3));
            int injected = 0;
            int exp_passes;
            int exp_ovr;
            bit ok = 1'b0;
            rdy_mode = 2; mode = 1'b1;
            pulse_tick;
            for (int i = 0; i < 800; i++) begin
                tick = 1'b0;
                exp_passes = (injected > 0) ? 2 : 1;
                if (done_cnt - d0 >= exp_passes && !busy) begin
                    ok = 1'b1;
                    break;
                end
                eng_idle = ($urandom_range(0, 3) != 0);
                step = 1'($urandom_range(0, 1));
                if (injected < want_extra && req_valid && hs_row.size() - h0 < CELLS &&
                    $urandom_range(0, 3) == 0) begin
                    tick = 1'b1;
                    injected++;
                end
                clk_step;
            end
            tick = 1'b0; step = 1'b0; eng_idle = 1'b1;
            repeat (5) clk_step;
            exp_passes = (injected > 0) ? 2 : 1;
            exp_ovr = (injected > 1) ? injected - 1 : 0;
            exp_gen = exp_gen + GEN_W'(exp_passes);
            if (exp_passes == 1) exp_buf = ~exp_buf;
            checks++; if (!ok || done_cnt - d0 != exp_passes) begin errors++; $display("FAIL rnd_passes[%0d]: got %0d want %0d", p, done_cnt - d0, exp_passes); end
            checks++; if (ovr_cnt - o0 != exp_ovr) begin errors++; $display("FAIL rnd_overrun[%0d]: got %0d want %0d", p, ovr_cnt - o0, exp_ovr); end
            checks++; if (seq_errors(h0, exp_passes) != 0) begin errors++; $display("FAIL rnd_coords[%0d]: got %0d bad entries want 0", p, seq_errors(h0, exp_passes)); end
            checks++; if (gen_count !== exp_gen || buf_sel !== exp_buf) begin errors++; $display("FAIL rnd_gen[%0d]: got gen=%0d buf=%b want gen=%0d buf=%b", p, gen_count, buf_sel, exp_gen, exp_buf); end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_drain;
        test_overrun;
        test_manual;
        test_mid_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
